// File: rtl/ahb3lite_pkg.sv
// AHB-Lite encodings shared by the request master, plus the request struct
// and the size/alignment helpers used on both sides of the lane aligner.
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_B8    = 3'b000;
  localparam logic [2:0] HSIZE_B16   = 3'b001;
  localparam logic [2:0] HSIZE_B32   = 3'b010;
  localparam logic [2:0] HSIZE_B64   = 3'b011;
  localparam logic [2:0] HSIZE_B128  = 3'b100;
  localparam logic [2:0] HSIZE_B256  = 3'b101;
  localparam logic [2:0] HSIZE_B512  = 3'b110;
  localparam logic [2:0] HSIZE_B1024 = 3'b111;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [63:0] wdata;
    logic        local_err;
  } ahb_req_t;

  // Only the low three address bits can matter on a 64-bit bus.
  function automatic logic size_misaligned(input logic [2:0] addr_lo, input logic [2:0] size);
    logic mis;
    case (size)
      HSIZE_B8:  mis = 1'b0;
      HSIZE_B16: mis = addr_lo[0];
      HSIZE_B32: mis = |addr_lo[1:0];
      HSIZE_B64: mis = |addr_lo[2:0];
      default:   mis = 1'b1;
    endcase
    return mis;
  endfunction

  function automatic logic [63:0] size_mask(input logic [2:0] size);
    logic [63:0] mask;
    case (size)
      HSIZE_B8:  mask = 64'h0000_0000_0000_00FF;
      HSIZE_B16: mask = 64'h0000_0000_0000_FFFF;
      HSIZE_B32: mask = 64'h0000_0000_FFFF_FFFF;
      default:   mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ahb_lane_align.sv
// Byte-lane steering for the 64-bit data bus: right-justified write data is
// moved onto its lanes, and read data is pulled back down and masked to size.
module ahb_lane_align
  import ahb3lite_pkg::*;
(
  input  logic [2:0]  addr_lo,
  input  logic [2:0]  size,
  input  logic [63:0] wdata,
  input  logic [63:0] hrdata,
  output logic [63:0] hwdata,
  output logic [63:0] rdata
);

  logic [63:0] mask;
  logic [5:0]  shamt;

  assign mask   = size_mask(size);
  assign shamt  = {addr_lo, 3'b000};
  assign hwdata = (wdata & mask) << shamt;
  assign rdata  = (hrdata >> shamt) & mask;

endmodule

// File: rtl/ahb_req_master.sv
// AHB-Lite single-transfer master: valid/ready requests in, NONSEQ/SINGLE transfers
// out, in-order responses back. Optional wait-state timeout: AHB_REQ_MASTER_TIMEOUT_EN.
module ahb_req_master
  import ahb3lite_pkg::*;
#(
  parameter logic [3:0]  HPROT_VAL      = 4'b0011,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [63:0] HWDATA,
  output logic        HSEL,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [63:0] HRDATA
);

  ahb_req_t    a_q, a_d, d_q, d_d, new_req;
  logic        a_valid_q, a_valid_d;
  logic        d_valid_q, d_valid_d;
  logic        cancel_q, cancel_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [63:0] rsp_rdata_q, rsp_rdata_d;
  logic [63:0] hwdata_lane, rd_lane;
  logic        accept;
  logic        hold_off;
  logic        unused_d_addr;

  assign unused_d_addr = ^d_q.addr[31:3];

  always_comb begin
    new_req.write     = req_write;
    new_req.addr      = req_addr;
    new_req.size      = req_size;
    new_req.wdata     = req_wdata;
    new_req.local_err = size_misaligned(req_addr[2:0], req_size);
  end

  ahb_lane_align u_lane_align (
    .addr_lo (d_q.addr[2:0]),
    .size    (d_q.size),
    .wdata   (d_q.wdata),
    .hrdata  (HRDATA),
    .hwdata  (hwdata_lane),
    .rdata   (rd_lane)
  );

  // A slot can only refill when it is empty or its address phase is being accepted now.
  assign req_ready = HRESETn && !hold_off && (!a_valid_q || (HREADY && !cancel_q));
  assign accept    = req_valid && req_ready;

  assign HTRANS = (a_valid_q && !a_q.local_err && !cancel_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HSEL   = (HTRANS == HTRANS_NONSEQ);
  assign HADDR  = a_q.addr;
  assign HWRITE = a_q.write;
  assign HSIZE  = a_q.size;
  assign HBURST = HBURST_SINGLE;
  assign HPROT  = HPROT_VAL;
  assign HWDATA = (d_valid_q && d_q.write && !d_q.local_err) ? hwdata_lane : 64'd0;

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

`ifdef AHB_REQ_MASTER_TIMEOUT_EN
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        flush_q, flush_d;
  logic        timeout;

  assign timeout  = !HREADY && d_valid_q && (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));
  assign hold_off = timeout || flush_q;

  always_comb begin
    to_cnt_d = (!HREADY && d_valid_q && !timeout) ? to_cnt_q + 16'd1 : 16'd0;
    flush_d  = timeout && a_valid_q;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      to_cnt_q <= 16'd0;
      flush_q  <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      flush_q  <= flush_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign hold_off       = 1'b0;
`endif

  always_comb begin
    a_valid_d   = a_valid_q;
    a_d         = a_q;
    d_valid_d   = d_valid_q;
    d_d         = d_q;
    cancel_d    = cancel_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 64'd0;
    if (HREADY) begin
      cancel_d = 1'b0;
      if (d_valid_q) begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = d_q.local_err | HRESP | cancel_q;
        rsp_rdata_d = (rsp_err_d || d_q.write) ? 64'd0 : rd_lane;
      end
      // After a two-cycle error the A slot was never put on the bus; keep it for reissue.
      if (cancel_q) begin
        d_valid_d = 1'b0;
      end else begin
        d_valid_d = a_valid_q;
        d_d       = a_q;
        a_valid_d = 1'b0;
      end
    end else if (HRESP && d_valid_q && !d_q.local_err) begin
      cancel_d = 1'b1;
    end
    if (accept) begin
      a_valid_d = 1'b1;
      a_d       = new_req;
    end
`ifdef AHB_REQ_MASTER_TIMEOUT_EN
    if (flush_q) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      rsp_rdata_d = 64'd0;
    end
    if (timeout) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      rsp_rdata_d = 64'd0;
      a_valid_d   = 1'b0;
      d_valid_d   = 1'b0;
      cancel_d    = 1'b0;
    end
`endif
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      a_valid_q   <= 1'b0;
      a_q         <= '0;
      d_valid_q   <= 1'b0;
      d_q         <= '0;
      cancel_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 64'd0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_q         <= a_d;
      d_valid_q   <= d_valid_d;
      d_q         <= d_d;
      cancel_q    <= cancel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_ahb_req_master.sv
// Bench for ahb_req_master: a small AHB-Lite memory slave, directed request
// vectors, and a scoreboard that checks every response in order.
module tb_ahb_req_master;
  import ahb3lite_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [2:0]  req_size = 3'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;
  logic [63:0] HRDATA = 64'd0;

  logic        req_ready, rsp_valid, rsp_err, HWRITE, HSEL;
  logic [63:0] rsp_rdata, HWDATA;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  always #5 HCLK = ~HCLK;

  ahb_req_master dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HPROT     (HPROT),
    .HWDATA    (HWDATA),
    .HSEL      (HSEL),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        err;
    logic        chk_data;
    logic [63:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] mem[int];

  function automatic exp_t ex(input logic err, input logic chk, input logic [63:0] d);
    return {err, chk, d};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mem_read(input logic [31:0] a);
    int k;
    k = int'(a >> 3);
    return mem.exists(k) ? mem[k] : 64'd0;
  endfunction

  function automatic void mem_write(input logic [31:0] a, input logic [2:0] s, input logic [63:0] d);
    int          k;
    int          lo;
    int          nb;
    logic [63:0] w;
    k  = int'(a >> 3);
    lo = int'(a[2:0]);
    nb = 1 << s;
    w  = mem.exists(k) ? mem[k] : 64'd0;
    for (int i = 0; i < 8; i++) begin
      if (i >= lo && i < lo + nb) w[8*i +: 8] = d[8*i +: 8];
    end
    mem[k] = w;
  endfunction

  // Memory slave: one data phase behind each accepted NONSEQ, no write on ERROR.
  logic        dp_valid = 1'b0;
  logic        dp_write = 1'b0;
  logic [31:0] dp_addr = 32'd0;
  logic [2:0]  dp_size = 3'd0;

  always @(posedge HCLK) begin
    if (HREADY) begin
      if (dp_valid && dp_write && !HRESP) mem_write(dp_addr, dp_size, HWDATA);
      if (HSEL && HTRANS == HTRANS_NONSEQ) begin
        dp_valid <= 1'b1;
        dp_write <= HWRITE;
        dp_addr  <= HADDR;
        dp_size  <= HSIZE;
        HRDATA   <= HWRITE ? 64'd0 : mem_read(HADDR);
      end else begin
        dp_valid <= 1'b0;
      end
    end
  end

  // Response scoreboard.
  always @(negedge HCLK) begin
    exp_t e;
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp err=%b data=%h, expected no response at %0t",
                 rsp_err, rsp_rdata, $time);
      end else begin
        e = exp_q.pop_front();
        check("rsp_err", 64'(rsp_err), 64'(e.err));
        if (e.chk_data) check("rsp_rdata", rsp_rdata, e.rdata);
      end
    end
  end

  int   ns_run = 0, ns_max = 0, rv_run = 0, rv_max = 0;
  logic saw_bad = 1'b0;

  always @(negedge HCLK) begin
    if (HTRANS == HTRANS_NONSEQ) begin
      ns_run++;
      if (ns_run > ns_max) ns_max = ns_run;
    end else ns_run = 0;
    if (rsp_valid === 1'b1) begin
      rv_run++;
      if (rv_run > rv_max) rv_max = rv_run;
    end else rv_run = 0;
    if (HTRANS == HTRANS_NONSEQ && HADDR == 32'h0000_4001) saw_bad = 1'b1;
  end

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic issue(input logic w, input logic [31:0] a, input logic [2:0] s,
                       input logic [63:0] wd, input logic push, input exp_t e);
    logic acc;
    acc       = 1'b0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_size  = s;
    req_wdata = wd;
    for (int i = 0; i < 40 && !acc; i++) begin
      #2;
      acc = req_ready;
      @(posedge HCLK);
      if (acc && push) exp_q.push_back(e);
      @(negedge HCLK);
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: request %h not accepted, expected acceptance", a);
    end
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge HCLK);
    repeat (2) @(negedge HCLK);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_htrans"}, 64'(HTRANS), 64'(HTRANS_IDLE));
    check({tag, "_hsel"}, 64'(HSEL), 64'd0);
    check({tag, "_haddr"}, 64'(HADDR), 64'd0);
    check({tag, "_hwrite"}, 64'(HWRITE), 64'd0);
    check({tag, "_hsize"}, 64'(HSIZE), 64'd0);
    check({tag, "_hwdata"}, HWDATA, 64'd0);
    check({tag, "_hburst"}, 64'(HBURST), 64'(HBURST_SINGLE));
    check({tag, "_hprot"}, 64'(HPROT), 64'h3);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 64'd0);
    check({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    mem[int'(32'h2000 >> 3)] = 64'h0123_4567_89AB_CDEF;
    mem[int'(32'h2008 >> 3)] = 64'h1111_2222_3333_4444;
    mem[int'(32'h2010 >> 3)] = 64'h5555_6666_7777_8888;
    mem[int'(32'h2018 >> 3)] = 64'h9999_AAAA_BBBB_CCCC;
    mem[int'(32'h3000 >> 3)] = 64'hCAFE_F00D_1234_5678;
    mem[int'(32'h3008 >> 3)] = 64'h0BAD_BEEF_0000_0001;
    mem[int'(32'h5008 >> 3)] = 64'h0F0F_0F0F_F0F0_F0F0;

    repeat (3) @(negedge HCLK);
    check_reset("por");
    HRESETn = 1'b1;
    @(negedge HCLK);

    // Write then read back a 32-bit word in the upper lanes.
    issue(1'b1, 32'h1004, HSIZE_B32, 64'hDEAD_BEEF, 1'b1, ex(1'b0, 1'b1, 64'd0));
    issue(1'b0, 32'h1004, HSIZE_B32, 64'd0, 1'b1, ex(1'b0, 1'b1, 64'h0000_0000_DEAD_BEEF));
    check("wr_hwdata", HWDATA, 64'hDEAD_BEEF_0000_0000);
    check("rd_haddr", 64'(HADDR), 64'h1004);
    check("rd_hwrite", 64'(HWRITE), 64'd0);
    idle();
    drain();

    // Four back-to-back 64-bit reads.
    ns_max = 0;
    rv_max = 0;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 32'h2000 + 32'(8 * i), HSIZE_B64, 64'd0, 1'b1,
            ex(1'b0, 1'b1, mem_read(32'h2000 + 32'(8 * i))));
    end
    idle();
    drain();
    check("b2b_nonseq_run", 64'(ns_max), 64'd4);
    check("b2b_rsp_run", 64'(rv_max), 64'd4);

    // Three wait states in the data phase of 0x3000, next address held.
    issue(1'b0, 32'h3000, HSIZE_B64, 64'd0, 1'b1, ex(1'b0, 1'b1, 64'hCAFE_F00D_1234_5678));
    issue(1'b0, 32'h3008, HSIZE_B64, 64'd0, 1'b1, ex(1'b0, 1'b1, 64'h0BAD_BEEF_0000_0001));
    idle();
    HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      check("ws_haddr", 64'(HADDR), 64'h3008);
      check("ws_htrans", 64'(HTRANS), 64'(HTRANS_NONSEQ));
      check("ws_no_rsp", 64'(rsp_valid), 64'd0);
    end
    HREADY = 1'b1;
    drain();

    // Sub-word reads, then a misaligned halfword that must never reach the bus.
    issue(1'b0, 32'h2003, HSIZE_B8, 64'd0, 1'b1, ex(1'b0, 1'b1, 64'h89));
    issue(1'b0, 32'h200A, HSIZE_B16, 64'd0, 1'b1, ex(1'b0, 1'b1, 64'h3333));
    issue(1'b0, 32'h4001, HSIZE_B16, 64'd0, 1'b1, ex(1'b1, 1'b0, 64'd0));
    check("mis_htrans", 64'(HTRANS), 64'(HTRANS_IDLE));
    check("mis_hsel", 64'(HSEL), 64'd0);
    idle();
    drain();
    check("mis_never_issued", 64'(saw_bad), 64'd0);

    // Two-cycle ERROR on a write with a read queued behind it.
    issue(1'b1, 32'h5000, HSIZE_B64, 64'h1234_5678_9ABC_DEF0, 1'b1, ex(1'b1, 1'b1, 64'd0));
    issue(1'b0, 32'h5008, HSIZE_B64, 64'd0, 1'b1, ex(1'b0, 1'b1, 64'h0F0F_0F0F_F0F0_F0F0));
    idle();
    HREADY = 1'b0;
    HRESP  = 1'b1;
    @(negedge HCLK);
    HREADY = 1'b1;
    #1;
    check("err_c2_htrans", 64'(HTRANS), 64'(HTRANS_IDLE));
    check("err_c2_req_ready", 64'(req_ready), 64'd0);
    @(negedge HCLK);
    HRESP = 1'b0;
    check("err_reissue_htrans", 64'(HTRANS), 64'(HTRANS_NONSEQ));
    check("err_reissue_haddr", 64'(HADDR), 64'h5008);
    drain();

    // Reset with two transfers in flight: no responses may follow.
    issue(1'b0, 32'h2000, HSIZE_B64, 64'd0, 1'b0, ex(1'b0, 1'b0, 64'd0));
    issue(1'b0, 32'h2008, HSIZE_B64, 64'd0, 1'b0, ex(1'b0, 1'b0, 64'd0));
    idle();
    HRESETn = 1'b0;
    @(negedge HCLK);
    check_reset("midrst");
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (3) @(negedge HCLK);
    issue(1'b0, 32'h2010, HSIZE_B64, 64'd0, 1'b1, ex(1'b0, 1'b1, 64'h5555_6666_7777_8888));
    idle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_req_master.md
Name: ahb_req_master

Overview:
- AHB-Lite single-transfer master that turns a valid/ready request stream into NONSEQ/SINGLE transfers on a 64-bit AHB-Lite bus.
- Sits directly upstream of the bus slave memory/mailbox model and drives its HADDR/HTRANS/HWDATA.
- Overlaps the address phase of transfer N+1 with the data phase of transfer N.
- Returns one in-order response per request, with lane-extracted read data and error status.

Parameters:
- HPROT_VAL, 4'b0011, constant HPROT driven on every transfer.
- TIMEOUT_CYCLES, 256, wait-state limit; used only when the optional feature is compiled in.

Ports:
- HCLK  in  1  bus clock
- HRESETn  in  1  synchronous active-low reset
- req_valid  in  1  request offered
- req_ready  out  1  request accepted when req_valid && req_ready
- req_write  in  1  1 = write
- req_addr  in  32  byte address
- req_size  in  3  HSIZE encoding; only B8/B16/B32/B64 are legal
- req_wdata  in  64  right-justified write data
- rsp_valid  out  1  one-cycle response pulse; no backpressure
- rsp_rdata  out  64  right-justified read data; 0 for writes
- rsp_err  out  1  bus ERROR, misalignment or timeout
- HADDR  out  32
- HTRANS  out  2
- HWRITE  out  1
- HSIZE  out  3
- HBURST  out  3  always SINGLE
- HPROT  out  4  HPROT_VAL
- HWDATA  out  64
- HSEL  out  1  high whenever HTRANS is NONSEQ
- HREADY  in  1  slave HREADYOUT
- HRESP  in  1
- HRDATA  in  64

Behaviour:
- Two register slots:
  - A-slot: address phase, {valid, local_err, write, addr, size, wdata}.
  - D-slot: data phase, same fields.
- HTRANS = NONSEQ when A valid, A not local_err and no cancel is active; otherwise IDLE.
- HADDR/HWRITE/HSIZE are driven from A, and held stable while HREADY=0.
- req_ready = !A.valid || (HREADY && !cancel). This is combinational on HREADY.
- On an HCLK edge with HREADY=1:
  - If D valid, emit the response for D.
  - Move A to D.
  - Load a new request into A if one is accepted; otherwise clear A.valid.
- HWDATA is driven from D: req_wdata shifted left by 8*addr[2:0]. Lanes outside the size are 0.
- rsp_rdata = HRDATA >> 8*addr[2:0], masked to the size width.
- Response timing: rsp_valid is registered, one cycle after the HREADY=1 edge that completes the data phase.
  - Best-case latency, request accepted to rsp_valid: 3 cycles.
  - Back-to-back throughput: 1 transfer per cycle.
- Misalignment: addr not aligned to size, or size > B64, is accepted with local_err=1.
  - No bus transfer is made (HTRANS=IDLE in its slot).
  - It flows through both slots in order and responds with rsp_err=1.
- Two-cycle error response:
  - Cycle 1: HREADY=0, HRESP=1 with D valid. Set cancel.
  - Cycle 2: HTRANS=IDLE (A is retained, not dropped) and req_ready=0.
  - On the following HREADY=1 edge: D responds with rsp_err=1, and cancel clears.
  - A is then reissued as NONSEQ.
- Single-cycle error (HREADY=1, HRESP=1): D responds with err; no cancel.
- Reset (HRESETn=0 at an edge), including mid-operation:
  - Both slots are cleared and no response is emitted for in-flight requests.
  - Outputs: HTRANS=IDLE, HSEL=0, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, HBURST=SINGLE, HPROT=HPROT_VAL, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0 during reset.
- Simultaneous D-completion and new request acceptance is legal in the same cycle.

Optional Feature:
- Macro: AHB_REQ_MASTER_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit counter counts consecutive HREADY=0 cycles while D valid.
  - When it reaches TIMEOUT_CYCLES, D responds rsp_err=1 with rdata 0.
  - Both slots are then flushed: a valid A also responds rsp_err=1 on the next cycle.
  - The master returns to idle.
- Without the macro: no counter, and the master waits indefinitely.

Decomposition:
- ahb3lite_pkg already holds HTRANS_*, HSIZE_*, HBURST_*, HRESP_*.
- Add to ahb3lite_pkg:
  - ahb_req_t packed struct {write, addr, size, wdata, local_err}.
  - function size_misaligned(addr, size).
- One sub-module: ahb_lane_align, combinational write-lane shift plus read-lane extract/mask, instantiated once.

Test Plan:
- Write B32 0xDEADBEEF to 0x00001004, then read B32 from 0x00001004:
  - HWDATA = 0xDEADBEEF_00000000.
  - Read rsp_rdata = 0x00000000DEADBEEF, rsp_err=0.
- Four back-to-back B64 reads from 0x2000–0x2018 with HREADY=1:
  - HTRANS NONSEQ on 4 consecutive cycles.
  - 4 consecutive rsp_valid pulses, in order.
- Slave holds HREADY=0 for 3 cycles during read of 0x3000:
  - HADDR stays 0x3000-next stable.
  - rsp_valid exactly once, after HREADY returns.
- B16 to 0x4001:
  - No NONSEQ issued.
  - rsp_err=1 in order after the preceding request.
- Two-cycle ERROR on write to 0x5000 with a queued read at 0x5008:
  - HTRANS=IDLE in the second error cycle.
  - Write responds err=1; read reissued and responds err=0.
- Reset asserted while 2 transfers are in flight:
  - No rsp_valid.
  - All outputs at their reset values at the first edge.
